// File: rtl/suprloco_pkg.sv
// Shared constants and types for the Super Locomotive ROM loader.
// Region map of the index-0 download stream, index codes, FSM and select types.
package suprloco_pkg;

    localparam logic [26:0] MAIN_BASE = 27'h000_0000;
    localparam logic [26:0] MAIN_SIZE = 27'h000_C000;
    localparam logic [26:0] SND_BASE  = MAIN_BASE + MAIN_SIZE;
    localparam logic [26:0] SND_SIZE  = 27'h000_1000;
    localparam logic [26:0] TILE_BASE = SND_BASE + SND_SIZE;
    localparam logic [26:0] TILE_SIZE = 27'h000_6000;
    localparam logic [26:0] SPR_BASE  = TILE_BASE + TILE_SIZE;
    localparam logic [26:0] SPR_SIZE  = 27'h000_8000;
    localparam logic [26:0] PROM_BASE = SPR_BASE + SPR_SIZE;
    localparam logic [26:0] PROM_SIZE = 27'h000_0400;
    localparam logic [26:0] ROM_TOTAL = 27'h001_B400;

    localparam logic [16:0] CNT_MAX = 17'h1_FFFF;

    localparam logic [15:0] IDX_ROM = 16'd0;
    localparam logic [15:0] IDX_DIP = 16'd254;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LATCH,
        ST_WRITE,
        ST_RELEASE
    } ld_state_e;

    typedef enum logic [4:0] {
        SEL_NONE = 5'b00000,
        SEL_MAIN = 5'b00001,
        SEL_SND  = 5'b00010,
        SEL_TILE = 5'b00100,
        SEL_SPR  = 5'b01000,
        SEL_PROM = 5'b10000
    } rom_sel_e;

endpackage

// File: rtl/suprloco_region_decode.sv
// Maps a download-stream offset onto a ROM region select and a
// region-local byte address; flags offsets past the end of the image.
module suprloco_region_decode
    import suprloco_pkg::*;
(
    input  logic [26:0] i_addr,
    output rom_sel_e    o_sel,
    output logic [15:0] o_local,
    output logic        o_oor
);

    logic [15:0] base;

    // Region lookup by ascending base; local address is offset from that base.
    always_comb begin
        o_sel = SEL_NONE;
        base  = 16'h0000;
        o_oor = 1'b0;
        if (i_addr < SND_BASE) begin
            o_sel = SEL_MAIN;
            base  = MAIN_BASE[15:0];
        end else if (i_addr < TILE_BASE) begin
            o_sel = SEL_SND;
            base  = SND_BASE[15:0];
        end else if (i_addr < SPR_BASE) begin
            o_sel = SEL_TILE;
            base  = TILE_BASE[15:0];
        end else if (i_addr < PROM_BASE) begin
            o_sel = SEL_SPR;
            base  = SPR_BASE[15:0];
        end else if (i_addr < PROM_BASE + PROM_SIZE) begin
            o_sel = SEL_PROM;
            base  = PROM_BASE[15:0];
        end else begin
            o_oor = 1'b1;
        end
        o_local = i_addr[15:0] - base;
    end

endmodule

// File: rtl/suprloco_rom_loader.sv
// HPS ioctl download front end: steers ROM bytes into region writes,
// captures DIP bytes, tracks load completion and holds the core in reset.
module suprloco_rom_loader
    import suprloco_pkg::*;
(
    input  logic        i_EMU_MCLK,
    input  logic        i_EMU_INITRST,
    input  logic [15:0] ioctl_index,
    input  logic        ioctl_download,
    input  logic [26:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        ioctl_wr,
    output logic        ioctl_wait,
    output logic [15:0] o_ROM_ADDR,
    output logic [7:0]  o_ROM_DATA,
    output logic        o_ROM_WR,
    output logic [4:0]  o_ROM_SEL,
    output logic [7:0]  o_DIP0,
    output logic [7:0]  o_DIP1,
    output logic        o_ROM_LOADED,
    output logic        o_CORE_RST,
    output logic        o_LOAD_ERR
);

    ld_state_e   state_q, state_d;
    logic [26:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic [15:0] idx_q, idx_d;
    logic        wait_q, wait_d;
    logic        rom_wr_q, rom_wr_d;
    logic [4:0]  rom_sel_q, rom_sel_d;
    logic [15:0] rom_addr_q, rom_addr_d;
    logic [7:0]  rom_data_q, rom_data_d;
    logic [7:0]  dip0_q, dip0_d;
    logic [7:0]  dip1_q, dip1_d;
    logic        loaded_q, loaded_d;
    logic        err_q, err_d;
    logic        core_rst_q, core_rst_d;
    logic [16:0] cnt_q, cnt_d;
    logic        dl_q, dl_d;
    logic        pend_q, pend_d;

    rom_sel_e    dec_sel;
    logic [15:0] dec_local;
    logic        dec_oor;

    logic        idx_rom;
    logic        dl_start;
    logic        dl_end;
    logic        accept;

    suprloco_region_decode u_dec (
        .i_addr  (addr_q),
        .o_sel   (dec_sel),
        .o_local (dec_local),
        .o_oor   (dec_oor)
    );

    assign idx_rom  = (ioctl_index == IDX_ROM);
    assign dl_start = ioctl_download & ~dl_q & idx_rom;
    assign dl_end   = ~ioctl_download & dl_q & idx_rom;
    assign accept   = (state_q == ST_IDLE) & ioctl_wr & ioctl_download;

    // Next-state: byte FSM, counter, sticky flags and deferred end-of-load check.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        idx_d      = idx_q;
        wait_d     = wait_q;
        rom_wr_d   = rom_wr_q;
        rom_sel_d  = rom_sel_q;
        rom_addr_d = rom_addr_q;
        rom_data_d = rom_data_q;
        dip0_d     = dip0_q;
        dip1_d     = dip1_q;
        loaded_d   = loaded_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        dl_d       = ioctl_download;
        core_rst_d = ~loaded_q | (ioctl_download & idx_rom);

        if (dl_start) begin
            cnt_d    = '0;
            loaded_d = 1'b0;
            err_d    = 1'b0;
            pend_d   = 1'b0;
        end

        if (accept && idx_rom && (cnt_d != CNT_MAX)) begin
            cnt_d = cnt_d + 17'd1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_LATCH;
                    addr_d  = ioctl_addr;
                    data_d  = ioctl_data;
                    idx_d   = ioctl_index;
                    wait_d  = 1'b1;
                end
            end
            ST_LATCH: begin
                state_d   = ST_WRITE;
                wait_d    = 1'b1;
                rom_sel_d = SEL_NONE;
                if (idx_q == IDX_ROM) begin
                    if (dec_oor) begin
                        err_d = 1'b1;
                    end else begin
                        rom_wr_d   = 1'b1;
                        rom_sel_d  = dec_sel;
                        rom_addr_d = dec_local;
                        rom_data_d = data_q;
                    end
                end else if (idx_q == IDX_DIP) begin
                    if (addr_q == 27'd0) begin
                        dip0_d = data_q;
                    end else if (addr_q == 27'd1) begin
                        dip1_d = data_q;
                    end
                end
            end
            ST_WRITE: begin
                state_d  = ST_RELEASE;
                wait_d   = 1'b1;
                rom_wr_d = 1'b0;
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
                wait_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                wait_d  = 1'b0;
            end
        endcase

        if (ioctl_wr && (state_q != ST_IDLE)) begin
            err_d = 1'b1;
        end

        if ((dl_end || pend_q) && !dl_start) begin
            if (state_q == ST_IDLE) begin
                loaded_d = (cnt_q >= ROM_TOTAL[16:0]) && !err_q;
                pend_d   = 1'b0;
            end else begin
                pend_d = 1'b1;
            end
        end
    end

    // State and registered outputs; reset abandons any byte in flight.
    always_ff @(posedge i_EMU_MCLK or posedge i_EMU_INITRST) begin
        if (i_EMU_INITRST) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            idx_q      <= '0;
            wait_q     <= 1'b0;
            rom_wr_q   <= 1'b0;
            rom_sel_q  <= SEL_NONE;
            rom_addr_q <= '0;
            rom_data_q <= '0;
            dip0_q     <= 8'hFF;
            dip1_q     <= 8'hFF;
            loaded_q   <= 1'b0;
            err_q      <= 1'b0;
            core_rst_q <= 1'b1;
            cnt_q      <= '0;
            dl_q       <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            idx_q      <= idx_d;
            wait_q     <= wait_d;
            rom_wr_q   <= rom_wr_d;
            rom_sel_q  <= rom_sel_d;
            rom_addr_q <= rom_addr_d;
            rom_data_q <= rom_data_d;
            dip0_q     <= dip0_d;
            dip1_q     <= dip1_d;
            loaded_q   <= loaded_d;
            err_q      <= err_d;
            core_rst_q <= core_rst_d;
            cnt_q      <= cnt_d;
            dl_q       <= dl_d;
            pend_q     <= pend_d;
        end
    end

    assign ioctl_wait   = wait_q;
    assign o_ROM_WR     = rom_wr_q;
    assign o_ROM_SEL    = rom_sel_q;
    assign o_ROM_ADDR   = rom_addr_q;
    assign o_ROM_DATA   = rom_data_q;
    assign o_DIP0       = dip0_q;
    assign o_DIP1       = dip1_q;
    assign o_ROM_LOADED = loaded_q;
    assign o_LOAD_ERR   = err_q;
    assign o_CORE_RST   = core_rst_q;

endmodule

// File: tb/tb_suprloco_rom_loader.sv
// Self-checking bench for suprloco_rom_loader: vector table, random
// frames against a region-map model, and multi-cycle corner sequences.
module tb_suprloco_rom_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ioctl_index;
    logic        ioctl_download;
    logic [26:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        ioctl_wr;
    logic        ioctl_wait;
    logic [15:0] o_ROM_ADDR;
    logic [7:0]  o_ROM_DATA;
    logic        o_ROM_WR;
    logic [4:0]  o_ROM_SEL;
    logic [7:0]  o_DIP0;
    logic [7:0]  o_DIP1;
    logic        o_ROM_LOADED;
    logic        o_CORE_RST;
    logic        o_LOAD_ERR;

    int checks = 0;
    int failures = 0;
    logic [16:0] preload_v;

    suprloco_rom_loader dut (
        .i_EMU_MCLK     (clk),
        .i_EMU_INITRST  (rst),
        .ioctl_index    (ioctl_index),
        .ioctl_download (ioctl_download),
        .ioctl_addr     (ioctl_addr),
        .ioctl_data     (ioctl_data),
        .ioctl_wr       (ioctl_wr),
        .ioctl_wait     (ioctl_wait),
        .o_ROM_ADDR     (o_ROM_ADDR),
        .o_ROM_DATA     (o_ROM_DATA),
        .o_ROM_WR       (o_ROM_WR),
        .o_ROM_SEL      (o_ROM_SEL),
        .o_DIP0         (o_DIP0),
        .o_DIP1         (o_DIP1),
        .o_ROM_LOADED   (o_ROM_LOADED),
        .o_CORE_RST     (o_CORE_RST),
        .o_LOAD_ERR     (o_LOAD_ERR)
    );

    always #10 clk = ~clk;

    // Region map model: base/size per region, select bit = region position.
    localparam int unsigned RB [5] = '{32'h00000, 32'h0C000, 32'h0D000, 32'h13000, 32'h1B000};
    localparam int unsigned RS [5] = '{32'h0C000, 32'h01000, 32'h06000, 32'h08000, 32'h00400};

    function automatic void ref_decode(input logic [26:0] a, output logic [4:0] sel,
                                       output logic [15:0] la, output bit hit);
        int unsigned av;
        int unsigned off;
        av = 32'(a);
        sel = 5'b0;
        la = 16'h0;
        hit = 1'b0;
        for (int r = 0; r < 5; r++) begin
            if (av >= RB[r] && av < RB[r] + RS[r]) begin
                sel = 5'(1 << r);
                off = av - RB[r];
                la = off[15:0];
                hit = 1'b1;
            end
        end
    endfunction

    typedef struct {
        logic [15:0] idx;
        logic [26:0] addr;
        logic [7:0]  data;
        bit          wr;
        logic [4:0]  sel;
        logic [15:0] la;
        bit          err;
        logic [7:0]  dip0;
        logic [7:0]  dip1;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_dl(input logic [15:0] idx);
        ioctl_index = idx;
        ioctl_download = 1'b1;
        tick();
    endtask

    task automatic end_dl();
        ioctl_download = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic preload(input logic [16:0] v);
        preload_v = v;
        force dut.cnt_q = preload_v;
        tick();
        release dut.cnt_q;
    endtask

    task automatic send_byte(input logic [26:0] a, input logic [7:0] d,
                             output int wr_n, output int wr_cyc, output int wait_n,
                             output logic [4:0] sel2, output logic [15:0] la,
                             output logic [7:0] ld);
        ioctl_addr = a;
        ioctl_data = d;
        ioctl_wr = 1'b1;
        wr_n = 0;
        wr_cyc = 0;
        wait_n = 0;
        sel2 = '0;
        la = '0;
        ld = '0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            ioctl_wr = 1'b0;
            if (o_ROM_WR) begin
                wr_n++;
                wr_cyc = c;
                la = o_ROM_ADDR;
                ld = o_ROM_DATA;
            end
            if (ioctl_wait) wait_n++;
            if (c == 2) sel2 = o_ROM_SEL;
        end
    endtask

    task automatic inflight(input logic [26:0] a, output int wr_n);
        ioctl_addr = a;
        ioctl_data = 8'h42;
        ioctl_wr = 1'b1;
        wr_n = 0;
        tick();
        ioctl_wr = 1'b0;
        ioctl_download = 1'b0;
        for (int c = 0; c < 7; c++) begin
            tick();
            if (o_ROM_WR) wr_n++;
        end
    endtask

    initial begin
        #400000;
        failures++;
        $display("FAIL watchdog timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        int wr_n, wr_cyc, wait_n, n, bad;
        logic [4:0] sel2, esel;
        logic [15:0] la, ela, idx;
        logic [7:0] ld, d, m_dip0, m_dip1;
        logic [26:0] a;
        bit hit, m_err, ewr, ok;

        tbl[0]  = '{16'd0, 27'h0C010, 8'h5A, 1'b1, 5'b00010, 16'h0010, 1'b0, 8'hFF, 8'hFF};
        tbl[1]  = '{16'd0, 27'h00000, 8'h11, 1'b1, 5'b00001, 16'h0000, 1'b0, 8'hFF, 8'hFF};
        tbl[2]  = '{16'd0, 27'h0BFFF, 8'h22, 1'b1, 5'b00001, 16'hBFFF, 1'b0, 8'hFF, 8'hFF};
        tbl[3]  = '{16'd0, 27'h0D000, 8'h33, 1'b1, 5'b00100, 16'h0000, 1'b0, 8'hFF, 8'hFF};
        tbl[4]  = '{16'd0, 27'h12FFF, 8'h44, 1'b1, 5'b00100, 16'h5FFF, 1'b0, 8'hFF, 8'hFF};
        tbl[5]  = '{16'd0, 27'h13000, 8'h55, 1'b1, 5'b01000, 16'h0000, 1'b0, 8'hFF, 8'hFF};
        tbl[6]  = '{16'd0, 27'h1AFFF, 8'h66, 1'b1, 5'b01000, 16'h7FFF, 1'b0, 8'hFF, 8'hFF};
        tbl[7]  = '{16'd0, 27'h1B000, 8'h77, 1'b1, 5'b10000, 16'h0000, 1'b0, 8'hFF, 8'hFF};
        tbl[8]  = '{16'd0, 27'h1B3FF, 8'h88, 1'b1, 5'b10000, 16'h03FF, 1'b0, 8'hFF, 8'hFF};
        tbl[9]  = '{16'd254, 27'h1, 8'h3C, 1'b0, 5'b0, 16'h0, 1'b0, 8'hFF, 8'h3C};
        tbl[10] = '{16'd254, 27'h0, 8'hA5, 1'b0, 5'b0, 16'h0, 1'b0, 8'hA5, 8'h3C};
        tbl[11] = '{16'd254, 27'h5, 8'hE7, 1'b0, 5'b0, 16'h0, 1'b0, 8'hA5, 8'h3C};
        tbl[12] = '{16'd7, 27'h00100, 8'h99, 1'b0, 5'b0, 16'h0, 1'b0, 8'hA5, 8'h3C};
        tbl[13] = '{16'd0, 27'h1B400, 8'hC3, 1'b0, 5'b0, 16'h0, 1'b1, 8'hA5, 8'h3C};
        tbl[14] = '{16'd0, 27'h7FFFFFF, 8'hD4, 1'b0, 5'b0, 16'h0, 1'b1, 8'hA5, 8'h3C};

        rst = 1'b1;
        ioctl_index = '0;
        ioctl_download = 1'b0;
        ioctl_addr = '0;
        ioctl_data = '0;
        ioctl_wr = 1'b0;
        repeat (3) tick();
        chk("rst_wait", 32'(ioctl_wait), 32'd0);
        chk("rst_wr", 32'(o_ROM_WR), 32'd0);
        chk("rst_sel", 32'(o_ROM_SEL), 32'd0);
        chk("rst_addr", 32'(o_ROM_ADDR), 32'd0);
        chk("rst_data", 32'(o_ROM_DATA), 32'd0);
        chk("rst_dip0", 32'(o_DIP0), 32'hFF);
        chk("rst_dip1", 32'(o_DIP1), 32'hFF);
        chk("rst_loaded", 32'(o_ROM_LOADED), 32'd0);
        chk("rst_err", 32'(o_LOAD_ERR), 32'd0);
        chk("rst_core", 32'(o_CORE_RST), 32'd1);
        rst = 1'b0;
        tick();
        tick();
        chk("post_rst_core", 32'(o_CORE_RST), 32'd1);

        // Vector table: one byte per download frame.
        for (int i = 0; i < 15; i++) begin
            start_dl(tbl[i].idx);
            send_byte(tbl[i].addr, tbl[i].data, wr_n, wr_cyc, wait_n, sel2, la, ld);
            end_dl();
            chk($sformatf("v%0d_wrcnt", i), 32'(wr_n), tbl[i].wr ? 32'd1 : 32'd0);
            chk($sformatf("v%0d_sel", i), 32'(sel2), 32'(tbl[i].sel));
            chk($sformatf("v%0d_wait", i), 32'(wait_n), 32'd3);
            if (tbl[i].wr) begin
                chk($sformatf("v%0d_lat", i), 32'(wr_cyc), 32'd2);
                chk($sformatf("v%0d_addr", i), 32'(la), 32'(tbl[i].la));
                chk($sformatf("v%0d_data", i), 32'(ld), 32'(tbl[i].data));
            end
            chk($sformatf("v%0d_err", i), 32'(o_LOAD_ERR), 32'(tbl[i].err));
            chk($sformatf("v%0d_dip0", i), 32'(o_DIP0), 32'(tbl[i].dip0));
            chk($sformatf("v%0d_dip1", i), 32'(o_DIP1), 32'(tbl[i].dip1));
            chk($sformatf("v%0d_loaded", i), 32'(o_ROM_LOADED), 32'd0);
        end

        // Random frames against the model.
        m_err = 1'b1;
        m_dip0 = 8'hA5;
        m_dip1 = 8'h3C;
        for (int f = 0; f < 6; f++) begin
            case ($urandom_range(0, 2))
                0: idx = 16'd0;
                1: idx = 16'd254;
                default: idx = 16'd9;
            endcase
            if (idx == 16'd0) m_err = 1'b0;
            start_dl(idx);
            for (int b = 0; b < 12; b++) begin
                if (idx == 16'd0) a = 27'($urandom_range(0, 32'h1B7FF));
                else if (idx == 16'd254) a = 27'($urandom_range(0, 3));
                else a = 27'($urandom);
                d = 8'($urandom);
                ref_decode(a, esel, ela, hit);
                ewr = (idx == 16'd0) && hit;
                if (!ewr) esel = 5'b0;
                if (idx == 16'd0 && !hit) m_err = 1'b1;
                if (idx == 16'd254 && a == 27'd0) m_dip0 = d;
                if (idx == 16'd254 && a == 27'd1) m_dip1 = d;
                send_byte(a, d, wr_n, wr_cyc, wait_n, sel2, la, ld);
                ok = (wr_n == (ewr ? 1 : 0)) && (sel2 == esel) && (wait_n == 3) &&
                     (!ewr || (la == ela && ld == d && wr_cyc == 2));
                checks++;
                if (!ok) begin
                    failures++;
                    $display("FAIL rnd%0d_%0d idx=%0d addr=0x%0h actual wr=%0d sel=0x%0h la=0x%0h d=0x%0h wait=%0d required wr=%0d sel=0x%0h la=0x%0h d=0x%0h wait=3",
                             f, b, idx, a, wr_n, sel2, la, ld, wait_n, ewr, esel, ela, d);
                end
            end
            end_dl();
            chk($sformatf("rnd%0d_err", f), 32'(o_LOAD_ERR), 32'(m_err));
            chk($sformatf("rnd%0d_loaded", f), 32'(o_ROM_LOADED), 32'd0);
            chk($sformatf("rnd%0d_dip0", f), 32'(o_DIP0), 32'(m_dip0));
            chk($sformatf("rnd%0d_dip1", f), 32'(o_DIP1), 32'(m_dip1));
        end

        // Second strobe during WRITE is dropped and flagged.
        start_dl(16'd0);
        ioctl_addr = 27'h00100;
        ioctl_data = 8'h77;
        ioctl_wr = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        tick();
        n = 0;
        bad = 0;
        if (o_ROM_WR) n++;
        ioctl_addr = 27'h00200;
        ioctl_data = 8'h88;
        ioctl_wr = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            ioctl_wr = 1'b0;
            if (o_ROM_WR) begin
                n++;
                bad++;
            end
        end
        chk("drop_wrcnt", 32'(n), 32'd1);
        chk("drop_extra", 32'(bad), 32'd0);
        chk("drop_err", 32'(o_LOAD_ERR), 32'd1);
        end_dl();
        chk("drop_loaded", 32'(o_ROM_LOADED), 32'd0);

        // One byte short of a full image.
        start_dl(16'd0);
        preload(17'h1B3F0);
        n = 0;
        for (int i = 0; i < 15; i++) begin
            send_byte(27'h1B3F0 + 27'(i), 8'(i), wr_n, wr_cyc, wait_n, sel2, la, ld);
            n += wr_n;
        end
        end_dl();
        chk("short_wrcnt", 32'(n), 32'd15);
        chk("short_loaded", 32'(o_ROM_LOADED), 32'd0);
        chk("short_core", 32'(o_CORE_RST), 32'd1);
        chk("short_err", 32'(o_LOAD_ERR), 32'd0);

        // Full image.
        start_dl(16'd0);
        tick();
        chk("full_core_dl", 32'(o_CORE_RST), 32'd1);
        preload(17'h1B3F0);
        n = 0;
        for (int i = 0; i < 16; i++) begin
            send_byte(27'h1B3F0 + 27'(i), 8'(i), wr_n, wr_cyc, wait_n, sel2, la, ld);
            n += wr_n;
        end
        end_dl();
        chk("full_wrcnt", 32'(n), 32'd16);
        chk("full_loaded", 32'(o_ROM_LOADED), 32'd1);
        chk("full_core", 32'(o_CORE_RST), 32'd0);
        chk("full_err", 32'(o_LOAD_ERR), 32'd0);

        // New download clears loaded; out-of-range byte in flight at download end.
        start_dl(16'd0);
        chk("restart_loaded", 32'(o_ROM_LOADED), 32'd0);
        tick();
        chk("restart_core", 32'(o_CORE_RST), 32'd1);
        preload(17'h1B3FF);
        inflight(27'h1B400, wr_n);
        chk("fly_oor_wr", 32'(wr_n), 32'd0);
        chk("fly_oor_err", 32'(o_LOAD_ERR), 32'd1);
        chk("fly_oor_loaded", 32'(o_ROM_LOADED), 32'd0);

        // Valid final byte in flight at download end.
        start_dl(16'd0);
        preload(17'h1B3FF);
        inflight(27'h00050, wr_n);
        chk("fly_wr", 32'(wr_n), 32'd1);
        chk("fly_loaded", 32'(o_ROM_LOADED), 32'd1);
        chk("fly_core", 32'(o_CORE_RST), 32'd0);

        // Counter saturates instead of wrapping.
        start_dl(16'd0);
        preload(17'h1FFFF);
        send_byte(27'h00001, 8'h01, wr_n, wr_cyc, wait_n, sel2, la, ld);
        end_dl();
        chk("sat_loaded", 32'(o_ROM_LOADED), 32'd1);

        // Reset asserted while the write strobe is high.
        start_dl(16'd0);
        ioctl_addr = 27'h0C020;
        ioctl_data = 8'h6B;
        ioctl_wr = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        tick();
        chk("mid_pre_wr", 32'(o_ROM_WR), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_wr", 32'(o_ROM_WR), 32'd0);
        chk("mid_wait", 32'(ioctl_wait), 32'd0);
        chk("mid_core", 32'(o_CORE_RST), 32'd1);
        chk("mid_sel", 32'(o_ROM_SEL), 32'd0);
        chk("mid_addr", 32'(o_ROM_ADDR), 32'd0);
        chk("mid_data", 32'(o_ROM_DATA), 32'd0);
        chk("mid_dip0", 32'(o_DIP0), 32'hFF);
        chk("mid_dip1", 32'(o_DIP1), 32'hFF);
        chk("mid_loaded", 32'(o_ROM_LOADED), 32'd0);
        chk("mid_err", 32'(o_LOAD_ERR), 32'd0);
        ioctl_download = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        n = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (o_ROM_WR || ioctl_wait) n++;
        end
        chk("mid_after_quiet", 32'(n), 32'd0);
        chk("mid_after_core", 32'(o_CORE_RST), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/suprloco_rom_loader.md
SUPRLOCO_ROM_LOADER -- requirements
Module: suprloco_rom_loader

Interface
REQ-001 SHALL have ports: i_EMU_MCLK in 1 (sole clock, 40 MHz); i_EMU_INITRST in 1 (reset, asynchronous, active-high).
REQ-002 SHALL have ports: ioctl_index in 16; ioctl_download in 1; ioctl_addr in 27; ioctl_data in 8; ioctl_wr in 1 (one-cycle byte strobe); ioctl_wait out 1 (stall to HPS).
REQ-003 SHALL have ports: o_ROM_ADDR out 16 (region-local byte address); o_ROM_DATA out 8; o_ROM_WR out 1; o_ROM_SEL out 5 (one-hot: MAIN, SND, TILE, SPR, PROM).
REQ-004 SHALL have ports: o_DIP0 out 8; o_DIP1 out 8; o_ROM_LOADED out 1 (sticky); o_CORE_RST out 1 (high = hold game board in reset); o_LOAD_ERR out 1 (sticky).

Function
REQ-005 Region map, offsets into ioctl_index 0 stream: MAIN 0x00000-0x0BFFF; SND 0x0C000-0x0CFFF; TILE 0x0D000-0x12FFF; SPR 0x13000-0x1AFFF; PROM 0x1B000-0x1B3FF; total 0x1B400.
REQ-006 o_ROM_ADDR SHALL equal ioctl_addr minus region base, truncated to 16 bits.
REQ-007 FSM states IDLE, LATCH, WRITE, RELEASE; all transitions on rising i_EMU_MCLK.
REQ-008 IDLE: ioctl_wr=1 with ioctl_download=1 -> LATCH; addr, data, index captured that edge.
REQ-009 LATCH: decode region/DIP target; ioctl_wait=1; -> WRITE.
REQ-010 WRITE: o_ROM_WR=1 for exactly one cycle with registered addr/data/sel stable; ioctl_wait=1; -> RELEASE.
REQ-011 RELEASE: ioctl_wait=1, o_ROM_WR=0, o_ROM_SEL held; -> IDLE, ioctl_wait=0 following cycle.
REQ-012 Latency: ioctl_wr to o_ROM_WR = 2 cycles; ioctl_wait high for 3 cycles per byte.
REQ-013 ioctl_wr arriving in LATCH/WRITE/RELEASE SHALL be dropped and set o_LOAD_ERR.
REQ-014 index 0 byte with ioctl_addr >= 0x1B400 SHALL produce no o_ROM_WR, o_ROM_SEL=0, set o_LOAD_ERR; FSM still cycles LATCH->RELEASE.
REQ-015 index 254: addr 0 -> o_DIP0, addr 1 -> o_DIP1, updated in WRITE; other addrs ignored without error; o_ROM_WR stays 0.
REQ-016 Any other index: bytes consumed through FSM, no writes, no error.
REQ-017 Byte counter (17 bits) SHALL clear on rising ioctl_download with index 0, increment per accepted index-0 byte, saturate at 0x1FFFF.
REQ-018 On falling ioctl_download with index 0: counter >= 0x1B400 and o_LOAD_ERR=0 -> o_ROM_LOADED=1; else o_ROM_LOADED stays 0.
REQ-019 New index-0 download start SHALL clear o_ROM_LOADED and o_LOAD_ERR.
REQ-020 o_CORE_RST = ~o_ROM_LOADED | (ioctl_download & index==0), registered.
REQ-021 ioctl_download falling while FSM not IDLE: in-flight byte completes normally; edge evaluated after RELEASE.

Reset
REQ-022 Reset SHALL force: state IDLE; ioctl_wait=0; o_ROM_WR=0; o_ROM_SEL=0; o_ROM_ADDR=0; o_ROM_DATA=0; o_DIP0=0xFF; o_DIP1=0xFF; o_ROM_LOADED=0; o_LOAD_ERR=0; o_CORE_RST=1; counter=0.
REQ-023 Reset mid-byte SHALL abandon the byte with no write pulse.

Structure
REQ-024 Package suprloco_pkg SHALL hold region base/size constants, total 0x1B400, index codes 0 and 254, FSM state typedef, region one-hot typedef.
REQ-025 One sub-module natural: suprloco_region_decode (combinational addr -> sel, local addr, out-of-range).

Verification
REQ-026 ioctl_wr at addr 0x0C010 data 0x5A -> 2 cycles later o_ROM_WR=1, o_ROM_SEL=SND, o_ROM_ADDR=0x0010, o_ROM_DATA=0x5A; ioctl_wait high 3 cycles.
REQ-027 Full 0x1B400-byte index-0 download, download falls -> o_ROM_LOADED=1, o_CORE_RST=0 next cycle, o_LOAD_ERR=0.
REQ-028 Download of 0x1B3FF bytes only -> o_ROM_LOADED=0, o_CORE_RST=1.
REQ-029 Byte at 0x1B400 -> no o_ROM_WR, o_LOAD_ERR=1; second ioctl_wr during WRITE -> dropped, o_LOAD_ERR=1.
REQ-030 index 254 addr 1 data 0x3C -> o_DIP1=0x3C, o_DIP0=0xFF, no o_ROM_WR.
REQ-031 Reset asserted in WRITE -> o_ROM_WR=0, ioctl_wait=0, o_CORE_RST=1 immediately; all outputs at REQ-022 values.
